mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single memory port between the instruction-fetch requester and the data-access (load/store) requester of the pipelined RISC-V core. It accepts one request at a time and registers it into a request buffer. It drives the buffered request onto the memory request channel, then routes the read response back to the requester that owns it. Data accesses have priority, with a bounded-streak rule so fetch is never starved. It sits between the IF/MEM stages and the memory interface, and replaces ad-hoc staggering of fetch and load traffic.

## Interface
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch waits (legal range 1..15).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- inst_req_valid / inst_req_ready  in / out  1  fetch request handshake.
- inst_addr  in  32  fetch address, word aligned.
- inst_rsp_valid / inst_rsp_ready  out / in  1  fetch response handshake.
- inst_rdata  out  32  fetched instruction.
- data_req_valid / data_req_ready  in / out  1  data request handshake.
- data_addr  in  32  data address.
- data_wen  in  1  1 = store, 0 = load.
- data_wdata  in  32  store data.
- data_wstrb  in  4  byte strobes for a store.
- data_rsp_valid / data_rsp_ready  out / in  1  load response handshake.
- data_rdata  out  32  load data.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_addr  out  32  memory address.
- mem_wen  out  1  store enable.
- mem_wdata  out  32  store data.
- mem_wstrb  out  4  store strobes.
- mem_rsp_valid / mem_rsp_ready  in / out  1  memory read-response handshake.
- mem_rdata  in  32  read data.

## Operation
- FSM is one-hot, states IDLE, REQ, RSP. Reset enters IDLE.
- IDLE: grant selection.
  - Only data valid: grant data. Only inst valid: grant inst.
  - Both valid: grant data unless streak == MAX_DATA_STREAK, in which case grant inst.
  - The granted requester's req_ready is 1 combinationally. The other requester's req_ready is 0.
  - On the grant handshake, latch owner, addr, wen, wdata and wstrb into the buffer, then go to REQ.
  - Inst grants force wen = 0 and wstrb = 0.
- REQ: mem_req_valid = 1, driven from the buffer, stable until mem_req_ready.
  - On handshake with wen = 1: go to IDLE. Stores get no response.
  - On handshake with wen = 0: go to RSP.
- RSP: mem_rsp_ready = owner's rsp_ready. Owner's rsp_valid = mem_rsp_valid. Owner's rdata = mem_rdata (combinational).
  - Non-owner rsp_valid = 0.
  - On the response handshake: go to IDLE.
- Streak counter, 4 bits:
  - Increments on a data grant while inst_req_valid = 1.
  - Clears on an inst grant, or on a data grant while inst_req_valid = 0.
  - Saturates at MAX_DATA_STREAK.
- Exactly one transaction is outstanding. No requests are accepted in REQ or RSP, so both req_ready = 0 there.

## Timing
- Reset values:
  - All valid/ready outputs 0; mem_addr, mem_wdata, mem_wstrb, mem_wen 0; streak 0.
  - inst_rdata and data_rdata follow mem_rdata but are qualified by rsp_valid = 0.
- Reset asserted mid-transaction: asynchronous return to IDLE. The in-flight transaction is dropped; memory is reset together with the core.
- Latency with zero-wait memory:
  - Grant handshake in cycle 0; mem_req_valid = 1 in cycle 1.
  - Earliest response handshake in cycle 2.
  - Next grant possible in cycle 3, or cycle 2 after a store.
- A requester may drop req_valid only after its handshake. The arbiter never re-samples requester fields after the grant.
- Back-pressure:
  - mem_req_ready = 0 holds REQ with all mem_* outputs stable.
  - Owner rsp_ready = 0 holds RSP, and mem_rsp_ready = 0.
- Simultaneous first requests after reset (streak 0): data wins.

## Structure
- Shared package holds:
  - State encoding localparams: IDLE = 3'b001, REQ = 3'b010, RSP = 3'b100.
  - Owner encoding: OWN_INST = 1'b0, OWN_DATA = 1'b1.
  - The request-bus width macro: 69 bits = addr + wen + wdata + wstrb.
- One sub-module is natural: mem_req_buffer, the grant-latched request register with its load enable. The FSM, streak counter and response routing stay in the top module.

## Test plan
- Fetch only: inst_addr = 0x0, then 0x4, zero-wait memory returning 0x00000013. Require mem_addr = 0x0 in cycle 1, inst_rsp_valid with 0x00000013 in cycle 2, second mem_req_valid in cycle 4.
- Both valid continuously, MAX_DATA_STREAK = 4. Require grant order D, D, D, D, I, D, D, D, D, I.
- Store from data port: addr 0x100, wdata 0xDEADBEEF, wstrb 4'b0011. Require mem_wen = 1 and mem_wstrb = 0011; no data_rsp_valid; FSM back in IDLE after mem_req handshake.
- Back-pressure: mem_req_ready low 5 cycles, then data_rsp_ready low 3 cycles during a load. Require mem_addr stable, no new req_ready, inst_rsp_valid = 0 throughout.
- Load of 0x12345678 from 0x200 while fetch waits. Require only data_rsp_valid asserts with 0x12345678; fetch is granted next cycle.
- rst low for 1 cycle while in RSP. Require immediate IDLE, all outputs 0, streak 0; next request granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state and owner encodings,
// request bus width.
package mem_port_arbiter_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_REQ  = 3'b010;
  localparam logic [2:0] ST_RSP  = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    RSP  = ST_RSP
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Request bus layout, MSB first: addr[31:0], wen, wdata[31:0], wstrb[3:0].
  localparam int REQ_W = 69;

endpackage

// File: rtl/mem_port_arbiter_buf.sv
// Grant-latched request register. It captures the winner's request and its
// owner on the grant handshake and holds both until the next grant.
module mem_req_buffer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             own_in,
  input  logic [REQ_W-1:0] req_in,
  output logic             own,
  output logic [REQ_W-1:0] req
);

  // Capture the request on the grant handshake only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own <= OWN_INST;
      req <= '0;
    end else if (load) begin
      own <= own_in;
      req <= req_in;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter between instruction fetch and data access. One
// transaction is in flight at a time. Data wins ties unless it has already
// taken MAX_DATA_STREAK grants in a row while fetch was waiting.
//
// state | meaning
// IDLE  | choose a winner; accept its request into the buffer
// REQ   | present the buffered request to memory
// RSP   | route the memory read response to the owner
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  input  logic [31:0] inst_addr,
  output logic        inst_rsp_valid,
  input  logic        inst_rsp_ready,
  output logic [31:0] inst_rdata,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_rsp_valid,
  input  logic        data_rsp_ready,
  output logic [31:0] data_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_S = MAX_DATA_STREAK[3:0];

  state_t             state_q, state_nxt;
  logic [3:0]         streak_q, streak_nxt;
  logic               buf_load;
  logic               buf_own_in;
  logic [REQ_W-1:0]   buf_req_in;
  logic               buf_own;
  logic [REQ_W-1:0]   buf_req;
  logic               grant_data;
  logic               owner_ready;

  mem_req_buffer u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .own_in (buf_own_in),
    .req_in (buf_req_in),
    .own    (buf_own),
    .req    (buf_req)
  );

  assign {mem_addr, mem_wen, mem_wdata, mem_wstrb} = buf_req;

  // Read data is passed straight through; rsp_valid qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Data wins unless fetch is waiting and the data streak is exhausted.
  assign grant_data  = data_req_valid && (!inst_req_valid || (streak_q != MAX_S));
  assign owner_ready = (buf_own == OWN_DATA) ? data_rsp_ready : inst_rsp_ready;

  // State and streak registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_nxt;
      streak_q <= streak_nxt;
    end
  end

  // Next state, handshakes, buffer load and streak update.
  always_comb begin
    state_nxt      = state_q;
    streak_nxt     = streak_q;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    mem_req_valid  = 1'b0;
    mem_rsp_ready  = 1'b0;
    inst_rsp_valid = 1'b0;
    data_rsp_valid = 1'b0;
    buf_load       = 1'b0;
    buf_own_in     = OWN_DATA;
    buf_req_in     = {data_addr, data_wen, data_wdata, data_wstrb};
    unique case (state_q)
      IDLE: begin
        if (rst) begin
          if (grant_data) begin
            data_req_ready = 1'b1;
            buf_load       = 1'b1;
            state_nxt      = REQ;
            if (!inst_req_valid)      streak_nxt = 4'd0;
            else if (streak_q != MAX_S) streak_nxt = streak_q + 4'd1;
          end else if (inst_req_valid) begin
            inst_req_ready = 1'b1;
            buf_load       = 1'b1;
            buf_own_in     = OWN_INST;
            buf_req_in     = {inst_addr, 1'b0, 32'h0, 4'h0};
            state_nxt      = REQ;
            streak_nxt     = 4'd0;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = mem_wen ? IDLE : RSP;
      end
      RSP: begin
        mem_rsp_ready = owner_ready;
        if (buf_own == OWN_DATA) data_rsp_valid = mem_rsp_valid;
        else                     inst_rsp_valid = mem_rsp_valid;
        if (mem_rsp_valid && owner_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
